op_sequencer: RTL

- Programmable controller for the 4-register / W-accumulator ALU datapath: walks the program ROM over N words and issues a configurable micro-step sequence per word.
- Replaces the hard-wired t1..t4 controller.
- Drives ROM address, register load, operand selects, ALU op and W load.
- start/busy/done handshake to the surrounding system; config port to rewrite the per-word step table.

---
 rtl/op_sequencer_if.sv | 31 +++
 rtl/op_sequencer.sv | 78 +++++++
 2 files changed

// File: rtl/op_sequencer_if.sv
// op_sequencer_if: handshake, config and control-output bundle of the op sequencer
interface op_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int NSTEP  = 4
);
  localparam int SW = NSTEP > 1 ? $clog2(NSTEP) : 1;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] word_count;
  logic              cfg_we;
  logic [SW-1:0]     cfg_idx;
  logic [5:0]        cfg_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              load_reg;
  logic              sel_x;
  logic [1:0]        sel_y;
  logic [1:0]        op;
  logic              load_W;
  logic              result_valid;
  logic              busy;
  logic              done;
  logic              err;
  modport master (
    output start, abort, word_count, cfg_we, cfg_idx, cfg_data,
    input  rom_addr, load_reg, sel_x, sel_y, op, load_W, result_valid, busy, done, err
  );
  modport slave (
    input  start, abort, word_count, cfg_we, cfg_idx, cfg_data,
    output rom_addr, load_reg, sel_x, sel_y, op, load_W, result_valid, busy, done, err
  );
endinterface

// File: rtl/op_sequencer.sv
// op_sequencer: walks the program ROM and issues a programmable micro-step sequence per word
module op_sequencer #(
  parameter int ADDR_W = 4,
  parameter int NSTEP  = 4
) (
  input logic          clk,
  input logic          rst,
  op_sequencer_if.slave bus
);
  localparam int SW = NSTEP > 1 ? $clog2(NSTEP) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;
  state_t            state_q;
  logic [SW-1:0]     step_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic              err_q;
  logic [5:0]        store_q [NSTEP];
  logic [5:0]        ent;
  logic              exec;
  logic              illegal;
  logic              word_end;
  logic              last_word;
  function automatic logic [5:0] dflt(input int i);
    return i == 0 ? 6'h18 : i == 1 ? 6'h02 : i == 2 ? 6'h25 : 6'h00;
  endfunction
  // decode the active control-store entry; step-level outputs only live in EXEC
  always_comb begin
    ent              = store_q[step_q];
    exec             = state_q == EXEC;
    illegal          = ent[3:2] == 2'd3 || ent[1:0] == 2'd3;
    word_end         = ent[5] || step_q == SW'(NSTEP - 1);
    last_word        = addr_q == count_q - 1'b1;
    bus.rom_addr     = addr_q;
    bus.load_reg     = state_q == FETCH;
    bus.sel_x        = exec & ent[4];
    bus.sel_y        = exec ? ent[3:2] : 2'd0;
    bus.op           = exec ? ent[1:0] : 2'd0;
    bus.load_W       = exec & ~illegal;
    bus.result_valid = exec & ~illegal & word_end;
    bus.busy         = state_q == FETCH || state_q == EXEC;
    bus.done         = state_q == DONE;
    bus.err          = err_q | (exec & illegal);
  end
  // sequencer FSM plus control store; abort beats every FETCH/EXEC transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NSTEP; i++) store_q[i] <= dflt(i);
    end else begin
      if (bus.cfg_we && !bus.busy) store_q[bus.cfg_idx] <= bus.cfg_data;
      case (state_q)
        IDLE: if (bus.start) begin
          err_q   <= 1'b0;
          count_q <= bus.word_count;
          addr_q  <= '0;
          state_q <= bus.word_count != '0 ? FETCH : DONE;
        end
        FETCH: begin
          step_q  <= '0;
          state_q <= bus.abort ? IDLE : EXEC;
        end
        EXEC: if (bus.abort) state_q <= IDLE;
        else if (illegal) begin
          err_q   <= 1'b1;
          state_q <= DONE;
        end else if (word_end) begin
          addr_q  <= last_word ? addr_q : addr_q + 1'b1;
          state_q <= last_word ? DONE : FETCH;
        end else step_q <= step_q + 1'b1;
        DONE: state_q <= IDLE;
      endcase
    end
  end
endmodule
